pipe_mw: RTL and testbench



---
 rtl/mips_defs.sv | 55 +++++
 rtl/hctrl.sv | 39 +++
 rtl/load_ext.sv | 40 ++++
 rtl/pipe_mw.sv | 91 +++++++++
 tb/tb_pipe_mw.sv | 135 +++++++++++++
 5 files changed

// File: rtl/mips_defs.sv
// Shared MIPS definitions: opcode/funct encodings, register names and the
// decoded-control record produced by hctrl.
package mips_defs;

   localparam logic [5:0] OP_SPECIAL = 6'h00;
   localparam logic [5:0] OP_JAL     = 6'h03;
   localparam logic [5:0] OP_BEQ     = 6'h04;
   localparam logic [5:0] OP_ADDIU   = 6'h09;
   localparam logic [5:0] OP_SLTI    = 6'h0a;
   localparam logic [5:0] OP_SLTIU   = 6'h0b;
   localparam logic [5:0] OP_ANDI    = 6'h0c;
   localparam logic [5:0] OP_ORI     = 6'h0d;
   localparam logic [5:0] OP_XORI    = 6'h0e;
   localparam logic [5:0] OP_LUI     = 6'h0f;
   localparam logic [5:0] OP_LB      = 6'h20;
   localparam logic [5:0] OP_LH      = 6'h21;
   localparam logic [5:0] OP_LW      = 6'h23;
   localparam logic [5:0] OP_LBU     = 6'h24;
   localparam logic [5:0] OP_LHU     = 6'h25;
   localparam logic [5:0] OP_SB      = 6'h28;
   localparam logic [5:0] OP_SH      = 6'h29;
   localparam logic [5:0] OP_SW      = 6'h2b;

   localparam logic [5:0] F_SLL  = 6'h00;
   localparam logic [5:0] F_SRL  = 6'h02;
   localparam logic [5:0] F_SRA  = 6'h03;
   localparam logic [5:0] F_JR   = 6'h08;
   localparam logic [5:0] F_ADDU = 6'h21;
   localparam logic [5:0] F_SUBU = 6'h23;
   localparam logic [5:0] F_AND  = 6'h24;
   localparam logic [5:0] F_OR   = 6'h25;
   localparam logic [5:0] F_XOR  = 6'h26;
   localparam logic [5:0] F_NOR  = 6'h27;
   localparam logic [5:0] F_SLT  = 6'h2a;
   localparam logic [5:0] F_SLTU = 6'h2b;

   localparam logic [4:0]  REG_RA = 5'd31;
   localparam logic [31:0] NOP    = 32'h0;

   // Instruction classes plus register fields, as used by hazard and WB logic.
   typedef struct packed {
      logic       cal_r;
      logic       cal_i;
      logic       load;
      logic       jal;
      logic [4:0] rs;
      logic [4:0] rt;
      logic [4:0] rd;
   } hctrl_t;

   function automatic logic [5:0] opcode_of(input logic [31:0] instr);
      return instr[31:26];
   endfunction

endpackage

// File: rtl/hctrl.sv
// Hazard/control decoder: classifies an instruction and exposes rs/rt/rd.
import mips_defs::*;

module hctrl (
   input  logic [31:0] instr,
   output hctrl_t      ctrl
);

   logic [5:0] op;
   logic [5:0] funct;

   assign op    = opcode_of(instr);
   assign funct = instr[5:0];

   // Class decode; the all-zero nop decodes as sll $0 and writes nothing.
   always_comb begin
      ctrl       = '0;
      ctrl.rs    = instr[25:21];
      ctrl.rt    = instr[20:16];
      ctrl.rd    = instr[15:11];
      case (op)
         OP_SPECIAL: begin
            case (funct)
               F_SLL, F_SRL, F_SRA, F_ADDU, F_SUBU, F_AND, F_OR,
               F_XOR, F_NOR, F_SLT, F_SLTU: ctrl.cal_r = 1'b1;
               default: ctrl.cal_r = 1'b0;
            endcase
         end
         OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI:
            ctrl.cal_i = 1'b1;
         OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU:
            ctrl.load = 1'b1;
         OP_JAL:
            ctrl.jal = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: rtl/load_ext.sv
// Data-memory word to register value: byte/half select and sign/zero extend.
import mips_defs::*;

module load_ext (
   input  logic [5:0]  opcode,
   input  logic [1:0]  offset,
   input  logic [31:0] word,
   output logic [31:0] ext
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // Little-endian lane pick; halfword uses offset[1] only, so misaligned halves
   // silently round down.
   always_comb begin
      byte_sel = 8'h0;
      case (offset)
         2'd0: byte_sel = word[7:0];
         2'd1: byte_sel = word[15:8];
         2'd2: byte_sel = word[23:16];
         2'd3: byte_sel = word[31:24];
         default: byte_sel = 8'h0;
      endcase
      half_sel = offset[1] ? word[31:16] : word[15:0];
   end

   // Extension by opcode; lw (and anything unexpected) passes the word through.
   always_comb begin
      ext = word;
      case (opcode)
         OP_LB:   ext = {{24{byte_sel[7]}}, byte_sel};
         OP_LBU:  ext = {24'h0, byte_sel};
         OP_LH:   ext = {{16{half_sel[15]}}, half_sel};
         OP_LHU:  ext = {16'h0, half_sel};
         default: ext = word;
      endcase
   end

endmodule

// File: rtl/pipe_mw.sv
// M->W pipeline register with write-back value/address formation and a
// retired-instruction counter.
import mips_defs::*;

module pipe_mw #(
   parameter int          DW        = 32,
   parameter logic [31:0] RESET_PC8 = 32'h0000_3008
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          en,
   input  logic          flush,
   input  logic [DW-1:0] instrM,
   input  logic [DW-1:0] pc8M,
   input  logic [DW-1:0] aluM,
   input  logic [DW-1:0] dmM,
   output logic [DW-1:0] instrW,
   output logic [DW-1:0] pc8W,
   output logic [DW-1:0] wdataW,
   output logic [4:0]    waW,
   output logic          weW,
   output logic [31:0]   retired
);

   logic [DW-1:0] instr_q, pc8_q, alu_q, dm_q;
   logic [31:0]   ret_q;
   logic [31:0]   load_val;
   hctrl_t        ctrl;

   // W-stage registers: reset > flush > enable. Flush leaves pc8 alone.
   always_ff @(posedge clk) begin
      if (reset) begin
         instr_q <= NOP;
         pc8_q   <= RESET_PC8;
         alu_q   <= '0;
         dm_q    <= '0;
      end else if (flush) begin
         instr_q <= NOP;
         alu_q   <= '0;
         dm_q    <= '0;
      end else if (en) begin
         instr_q <= instrM;
         pc8_q   <= pc8M;
         alu_q   <= aluM;
         dm_q    <= dmM;
      end
   end

   // Count real instructions entering W; bubbles and flushed slots don't count.
   always_ff @(posedge clk) begin
      if (reset)
         ret_q <= '0;
      else if (!flush && en && instrM != NOP)
         ret_q <= ret_q + 32'd1;
   end

   hctrl u_hctrl (
      .instr (instr_q),
      .ctrl  (ctrl)
   );

   load_ext u_load_ext (
      .opcode (opcode_of(instr_q)),
      .offset (alu_q[1:0]),
      .word   (dm_q),
      .ext    (load_val)
   );

   // Destination register and write-back data, purely from W registers.
   always_comb begin
      waW = 5'd0;
      if (ctrl.cal_r)
         waW = ctrl.rd;
      else if (ctrl.cal_i || ctrl.load)
         waW = ctrl.rt;
      else if (ctrl.jal)
         waW = REG_RA;

      wdataW = alu_q;
      if (ctrl.jal)
         wdataW = pc8_q;
      else if (ctrl.load)
         wdataW = load_val;
   end

   assign weW     = (waW != 5'd0);
   assign instrW  = instr_q;
   assign pc8W    = pc8_q;
   assign retired = ret_q;

endmodule

// File: tb/tb_pipe_mw.sv
// Directed-vector bench for pipe_mw with a queue-based scoreboard.
module tb_pipe_mw;

   logic        clk = 1'b0;
   logic        reset, en, flush;
   logic [31:0] instrM, pc8M, aluM, dmM;
   logic [31:0] instrW, pc8W, wdataW, retired;
   logic [4:0]  waW;
   logic        weW;

   typedef struct {
      int          due;
      string       name;
      logic [31:0] instr;
      logic [31:0] pc8;
      logic [31:0] wdata;
      logic [4:0]  wa;
      logic        we;
      logic [31:0] ret;
   } exp_t;

   exp_t q[$];
   int   cyc = 0;
   int   vectors = 0;
   int   miscompares = 0;

   pipe_mw #(.DW(32), .RESET_PC8(32'h0000_3008)) dut (
      .clk     (clk),
      .reset   (reset),
      .en      (en),
      .flush   (flush),
      .instrM  (instrM),
      .pc8M    (pc8M),
      .aluM    (aluM),
      .dmM     (dmM),
      .instrW  (instrW),
      .pc8W    (pc8W),
      .wdataW  (wdataW),
      .waW     (waW),
      .weW     (weW),
      .retired (retired)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: results of edge N are visible at the following negedge.
   always @(negedge clk) begin
      while (q.size() > 0 && q[0].due == cyc) begin
         exp_t e;
         e = q.pop_front();
         vectors++;
         if (instrW !== e.instr || pc8W !== e.pc8 || wdataW !== e.wdata ||
             waW !== e.wa || weW !== e.we || retired !== e.ret) begin
            miscompares++;
            $display("FAIL %s: got instr=%h pc8=%h wdata=%h wa=%0d we=%b ret=%h want instr=%h pc8=%h wdata=%h wa=%0d we=%b ret=%h",
                     e.name, instrW, pc8W, wdataW, waW, weW, retired,
                     e.instr, e.pc8, e.wdata, e.wa, e.we, e.ret);
         end
      end
   end

   task automatic step(input string name, input logic r, input logic e_n,
                       input logic fl, input logic [31:0] i, input logic [31:0] p,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] x_instr, input logic [31:0] x_pc8,
                       input logic [31:0] x_wdata, input logic [4:0] x_wa,
                       input logic x_we, input logic [31:0] x_ret);
      exp_t e;
      reset = r; en = e_n; flush = fl;
      instrM = i; pc8M = p; aluM = a; dmM = d;
      e.due = cyc + 1; e.name = name;
      e.instr = x_instr; e.pc8 = x_pc8; e.wdata = x_wdata;
      e.wa = x_wa; e.we = x_we; e.ret = x_ret;
      q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      int n = 0;
      while (q.size() > 0 && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (q.size() > 0) begin
         miscompares++;
         $display("FAIL drain: got %0d pending want 0", q.size());
         q.delete();
      end
   endtask

   initial begin
      reset = 1'b1; en = 1'b0; flush = 1'b0;
      instrM = '0; pc8M = '0; aluM = '0; dmM = '0;
      #2;
      //    name       rst en fl instrM        pc8M          aluM          dmM           instrW        pc8W          wdataW        wa  we ret
      step("reset0",   1, 1, 0, 32'h00221821, 32'h00001234, 32'h0000_00AB, 32'h5555_5555, 32'h0, 32'h3008, 32'h0, 0, 0, 0);
      step("reset1",   1, 1, 0, 32'h8C070003, 32'h00005678, 32'h0000_0077, 32'h6666_6666, 32'h0, 32'h3008, 32'h0, 0, 0, 0);
      step("addu",     0, 1, 0, 32'h00221821, 32'h00003010, 32'h0000_00AB, 32'h0,        32'h00221821, 32'h3010, 32'h0000_00AB, 3, 1, 1);
      step("lb",       0, 1, 0, 32'h80050001, 32'h00003014, 32'h1,        32'h1234_80FF, 32'h80050001, 32'h3014, 32'hFFFF_FF80, 5, 1, 2);
      step("lbu",      0, 1, 0, 32'h90050001, 32'h00003018, 32'h1,        32'h1234_80FF, 32'h90050001, 32'h3018, 32'h0000_0080, 5, 1, 3);
      step("lh",       0, 1, 0, 32'h84060002, 32'h0000301C, 32'h2,        32'h8001_7FFF, 32'h84060002, 32'h301C, 32'hFFFF_8001, 6, 1, 4);
      step("lhu",      0, 1, 0, 32'h94060002, 32'h00003020, 32'h2,        32'h8001_7FFF, 32'h94060002, 32'h3020, 32'h0000_8001, 6, 1, 5);
      step("lw_mis",   0, 1, 0, 32'h8C070003, 32'h00003024, 32'h3,        32'hDEAD_BEEF, 32'h8C070003, 32'h3024, 32'hDEAD_BEEF, 7, 1, 6);
      step("lb_b3",    0, 1, 0, 32'h80080003, 32'h00003028, 32'h3,        32'h7F00_0000, 32'h80080003, 32'h3028, 32'h0000_007F, 8, 1, 7);
      step("jal",      0, 1, 0, 32'h0C000100, 32'h00003010, 32'h55,       32'h0,        32'h0C000100, 32'h3010, 32'h0000_3010, 31, 1, 8);
      step("ori_r0",   0, 1, 0, 32'h34000005, 32'h0000302C, 32'h5,        32'h0,        32'h34000005, 32'h302C, 32'h0000_0005, 0, 0, 9);
      step("flush",    0, 1, 1, 32'h00221821, 32'h00004000, 32'h99,       32'h0,        32'h0,        32'h302C, 32'h0,        0, 0, 9);
      step("addu2",    0, 1, 0, 32'h00221821, 32'h00003030, 32'h11,       32'h0,        32'h00221821, 32'h3030, 32'h0000_0011, 3, 1, 10);
      step("hold0",    0, 0, 0, 32'h80050001, 32'h00007000, 32'h1,        32'hFFFF_FFFF, 32'h00221821, 32'h3030, 32'h0000_0011, 3, 1, 10);
      step("hold1",    0, 0, 0, 32'h0C000100, 32'h00007004, 32'h2,        32'h0,        32'h00221821, 32'h3030, 32'h0000_0011, 3, 1, 10);
      step("hold2",    0, 0, 0, 32'h34000005, 32'h00007008, 32'h3,        32'h1,        32'h00221821, 32'h3030, 32'h0000_0011, 3, 1, 10);
      step("bubble",   0, 1, 0, 32'h0,        32'h00003034, 32'h99,       32'h0,        32'h0,        32'h3034, 32'h0000_0099, 0, 0, 10);
      step("lh_mis",   0, 1, 0, 32'h84090001, 32'h00003038, 32'h1,        32'h8001_7FFF, 32'h84090001, 32'h3038, 32'h0000_7FFF, 9, 1, 11);
      step("subu",     0, 1, 0, 32'h00225023, 32'h0000303C, 32'h7,        32'h0,        32'h00225023, 32'h303C, 32'h0000_0007, 10, 1, 12);
      drain();

      // Preload the counter just below wrap, then retire one more.
      @(negedge clk);
      #1;
      force dut.ret_q = 32'hFFFF_FFFF;
      #1;
      release dut.ret_q;
      step("wrap",     0, 1, 0, 32'h00221821, 32'h00003040, 32'h1,        32'h0,        32'h00221821, 32'h3040, 32'h0000_0001, 3, 1, 0);
      step("ret_more", 0, 1, 0, 32'h80050001, 32'h00003044, 32'h1,        32'h0000_FF00, 32'h80050001, 32'h3044, 32'hFFFF_FFFF, 5, 1, 1);
      step("rst_mid",  1, 1, 0, 32'h00221821, 32'h00003048, 32'h22,       32'h0,        32'h0,        32'h3008, 32'h0,        0, 0, 0);
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
